// File: rtl/screen_sel_seq.sv
// Frame-synchronous priority screen selector: latches a channel at frame_start, muxes ROM address and registers RGB on pixel_tick.
// Latency: selection 1 clk after frame_start, rgb 1 clk after a pixel_tick edge; no backpressure, outputs follow the video timing.
module screen_sel_seq #(
    parameter int                N_SCREENS    = 4,
    parameter int                RGB_W        = 3,
    parameter int                ADDR_W       = 11,
    parameter logic [RGB_W-1:0]  BG_RGB       = RGB_W'(1),
    parameter int                BLINK_FRAMES = 30,
    localparam int               SEL_W        = (N_SCREENS > 1) ? $clog2(N_SCREENS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pixel_tick,
    input  logic                          frame_start,
    input  logic                          video_on,
    input  logic [N_SCREENS-1:0]          ce,
    input  logic [N_SCREENS*RGB_W-1:0]    rgb_in,
    input  logic [N_SCREENS*ADDR_W-1:0]   addr_in,
    input  logic                          blink_en,
    output logic [RGB_W-1:0]              rgb,
    output logic [ADDR_W-1:0]             rom_addr,
    output logic [SEL_W-1:0]              active_sel,
    output logic                          active_valid,
    output logic                          switched
);

    localparam int CNT_W = $clog2(BLINK_FRAMES) + 1;

    typedef enum logic [1:0] {
        ST_NONE,
        ST_SHOW,
        ST_HIDE
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               switched_q, switched_d;
    logic [RGB_W-1:0]   rgb_q, rgb_d;

    logic [RGB_W-1:0]   ch_rgb  [N_SCREENS];
    logic [ADDR_W-1:0]  ch_addr [N_SCREENS];
    logic [SEL_W-1:0]   pend;
    logic               pend_valid;
    logic               sel_change;
    logic               show_ch;

    for (genvar g = 0; g < N_SCREENS; g++) begin : g_unpack
        assign ch_rgb[g]  = rgb_in[g*RGB_W +: RGB_W];
        assign ch_addr[g] = addr_in[g*ADDR_W +: ADDR_W];
    end

    // Ascending scan so the highest requesting index wins.
    always_comb begin
        pend       = '0;
        pend_valid = |ce;
        for (int i = 0; i < N_SCREENS; i++) begin
            if (ce[i]) begin
                pend = SEL_W'(i);
            end
        end
    end

    // sel is meaningless while idle, so going idle->idle never counts as a change.
    assign sel_change = (pend_valid != (state_q != ST_NONE)) ||
                        (pend_valid && (pend != sel_q));

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        switched_d = 1'b0;

        if (!blink_en) begin
            cnt_d = '0;
            if (state_q == ST_HIDE) begin
                state_d = ST_SHOW;
            end
        end

        if (frame_start) begin
            if (sel_change) begin
                switched_d = 1'b1;
                cnt_d      = '0;
                if (pend_valid) begin
                    sel_d   = pend;
                    state_d = ST_SHOW;
                end else begin
                    state_d = ST_NONE;
                end
            end else if (blink_en && (state_q != ST_NONE)) begin
                if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                    cnt_d   = '0;
                    state_d = (state_q == ST_SHOW) ? ST_HIDE : ST_SHOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // A HIDE state with blink_en already dropped shows the channel on this very tick.
    assign show_ch = (state_q == ST_SHOW) || ((state_q == ST_HIDE) && !blink_en);

    always_comb begin
        rgb_d = rgb_q;
        if (pixel_tick) begin
            if (!video_on) begin
                rgb_d = '0;
            end else if (show_ch) begin
                rgb_d = ch_rgb[sel_q];
            end else begin
                rgb_d = BG_RGB;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_NONE;
            sel_q      <= '0;
            cnt_q      <= '0;
            switched_q <= 1'b0;
            rgb_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            switched_q <= switched_d;
            rgb_q      <= rgb_d;
        end
    end

    assign rgb          = rgb_q;
    assign active_sel   = sel_q;
    assign active_valid = (state_q != ST_NONE);
    assign switched     = switched_q;
    assign rom_addr     = active_valid ? ch_addr[sel_q] : '0;

endmodule
